// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, one 32-bit word per frame.
// A miss latches the fetch address and holds a single memory read
// until the memory drops iwait, then fills the frame and returns to
// IDLE so the refetched word hits on the following cycle.
module icache_direct #(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        flush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned IW = $clog2(SETS);
    localparam int unsigned TW = 32 - IW - 2;

    typedef enum logic {
        IDLE,
        MISS
    } state_t;

    state_t          state;
    logic [31:0]     miss_addr;
    logic [SETS-1:0] valid;
    logic [TW-1:0]   tag_mem  [SETS];
    logic [31:0]     data_mem [SETS];

    logic [IW-1:0]   req_idx;
    logic [TW-1:0]   req_tag;
    logic [IW-1:0]   miss_idx;
    logic [TW-1:0]   miss_tag;
    logic            start_miss;
    logic            fill;
    logic            unused_bits;

    assign req_idx     = imemaddr[IW+1:2];
    assign req_tag     = imemaddr[31:IW+2];
    assign miss_idx    = miss_addr[IW+1:2];
    assign miss_tag    = miss_addr[31:IW+2];
    assign fill        = (state == MISS) && !iwait;
    assign unused_bits = ^{imemaddr[1:0], miss_addr[1:0]};

    // Lookup: hit only in IDLE, never while a flush is being applied
    always_comb begin
        ihit       = 1'b0;
        imemload   = '0;
        start_miss = 1'b0;
        if (state == IDLE && imemREN && !flush) begin
            ihit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
            start_miss = !ihit;
        end
        if (ihit) begin
            imemload = data_mem[req_idx];
        end
    end

    // Miss FSM with registered memory-side request and miss counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            miss_addr  <= '0;
            iREN       <= 1'b0;
            iaddr      <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_miss) begin
                        state     <= MISS;
                        miss_addr <= imemaddr;
                        iREN      <= 1'b1;
                        iaddr     <= {imemaddr[31:2], 2'b00};
                        if (miss_count != '1) begin
                            miss_count <= miss_count + 32'd1;
                        end
                    end
                end
                MISS: begin
                    if (!iwait) begin
                        state <= IDLE;
                        iREN  <= 1'b0;
                        iaddr <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    iREN  <= 1'b0;
                    iaddr <= '0;
                end
            endcase
        end
    end

    // Valid bits: flush overrides a coincident fill
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            valid <= '0;
        end else if (fill) begin
            valid[miss_idx] <= 1'b1;
        end
    end

    // Frame tag/data write on fill; reset abandons an in-flight fill
    always_ff @(posedge CLK) begin
        if (!RST && fill) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= iload;
        end
    end

    // Saturating hit-cycle counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count <= '0;
        end else if (ihit && hit_count != '1) begin
            hit_count <= hit_count + 32'd1;
        end
    end

endmodule
